// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Requester-side bundle for the nibble-serial add/subtract sequencer
// Revision : 1.0
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   sub;
    logic                   cin;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   sum;
    logic                   cout;
    logic                   overflow;

    modport master (
        output start, a, b, sub, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, sub, cin,
        output busy, done, sum, cout, overflow
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Time-shares one 4-bit ripple slice for a W-bit add/sub, LSB first
// Revision : 1.0
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_slice_sum;
    logic [4:0]        w_c;
    logic              w_last;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));

    // 4-bit ripple slice; w_c[3] is the carry into the nibble MSB for overflow
    always_comb begin
        w_c         = '0;
        w_slice_sum = '0;
        w_c[0]      = r_carry;
        for (int i = 0; i < 4; i++) begin
            w_slice_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
            w_c[i+1]       = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Subtract is A + ~B + 1, so the carry seed replaces cin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub | bus.cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
                    r_carry                    <= w_c[4];
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_c[4];
                        r_ovf   <= w_c[3] ^ w_c[4];
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add_ctrl
// Brief    : Directed and random checks of the nibble-serial add/sub sequencer
// Revision : 1.0
// ============================================================================
module tb_nibble_serial_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint to_signed(input logic [W-1:0] v);
        return v[W-1] ? (longint'(v) - (longint'(1) << W)) : longint'(v);
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on whole operands
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic ov);
        longint ua, ub, full, sres;
        longint smax, smin;
        ua   = longint'(a);
        ub   = longint'(b);
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        if (sub) begin
            full = ua - ub;
            co   = (ua >= ub);
            sres = to_signed(a) - to_signed(b);
        end else begin
            full = ua + ub + longint'(cin);
            co   = ((full >> W) != 0);
            sres = to_signed(a) + to_signed(b) + longint'(cin);
        end
        s  = full[W-1:0];
        ov = (sres > smax) || (sres < smin);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        logic [W-1:0] es;
        logic         eco, eov;
        model(a, b, sub, cin, es, eco, eov);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom);
        check({tag, ".busy0"}, 64'(bus.busy), 64'd1);
        check({tag, ".done0"}, 64'(bus.done), 64'd0);
        for (int i = 1; i < NIBBLES; i++) begin
            @(posedge clk); #1;
            check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        end
        @(posedge clk); #1;
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        check({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, ".sum"}, 64'(bus.sum), 64'(es));
        check({tag, ".cout"}, 64'(bus.cout), 64'(eco));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(eov));
        @(posedge clk); #1;
        check({tag, ".done_drop"}, 64'(bus.done), 64'd0);
        check({tag, ".sum_hold"}, 64'(bus.sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] es;
        logic         eco, eov;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.sum", 64'(bus.sum), 64'd0);
        check("rst.cout", 64'(bus.cout), 64'd0);
        check("rst.ovf", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_basic",  16'h1234, 16'h0FCD, 1'b0, 1'b0);
        run_op("carry_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("cin_only",   16'h0FFF, 16'h0000, 1'b0, 1'b1);
        run_op("sgn_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0);

        // Reset in RUN cycle 2 must clear everything and suppress done
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst.busy", 64'(bus.busy), 64'd0);
        check("midrst.sum", 64'(bus.sum), 64'd0);
        check("midrst.cout", 64'(bus.cout), 64'd0);
        check("midrst.ovf", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst.no_done", 64'(bus.done), 64'd0);
        end

        // rst and start together: reset wins
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.a = 16'h0101; bus.b = 16'h0202;
        @(posedge clk); #1;
        check("rststart.busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check("rststart.idle", 64'(bus.busy), 64'd0);
        check("rststart.done", 64'(bus.done), 64'd0);

        // start during RUN is ignored
        @(negedge clk);
        bus.a = 16'h0001; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'h1111; bus.b = 16'h1111; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("reject.busy", 64'(bus.busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("reject.done", 64'(bus.done), 64'd1);
        check("reject.sum", 64'(bus.sum), 64'h0002);
        @(posedge clk); #1;
        check("reject.not_taken", 64'(bus.busy), 64'd0);
        check("reject.done_drop", 64'(bus.done), 64'd0);

        // Back-to-back with start held through DONE
        model(16'h0003, 16'h0004, 1'b0, 1'b0, es, eco, eov);
        @(negedge clk);
        bus.a = 16'h0003; bus.b = 16'h0004; bus.start = 1'b1;
        @(posedge clk);
        repeat (NIBBLES) @(posedge clk);
        #1;
        check("b2b.done1", 64'(bus.done), 64'd1);
        check("b2b.sum1", 64'(bus.sum), 64'(es));
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b.reaccept", 64'(bus.busy), 64'd1);
        check("b2b.gap", 64'(bus.done), 64'd0);
        repeat (NIBBLES - 1) @(posedge clk);
        #1;
        check("b2b.not_yet", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        check("b2b.done2", 64'(bus.done), 64'd1);
        check("b2b.sum2", 64'(bus.sum), 64'(es));
        @(posedge clk);

        for (int n = 0; n < 24; n++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
